mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single data-memory port between the CPU and a host/debug requester
//  (e.g. a UART loader or monitor). CPU traffic passes straight through; host
//  accesses are inserted by stalling the CPU through its busy line.
//  Sits between cpu and memory. Guarantees the CPU a minimum number of
//  completed accesses between host slots, and supports a host-driven CPU halt.
// PARAMETERS
//  ADDR_WIDTH  16  memory address width
//  DATA_WIDTH  16  memory data width
//  CPU_SLOTS    4  completed CPU accesses required before each host grant (>=1)
// PORTS
//  clk          in   1   system clock; everything runs on its rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  cpu_address  in   AW  CPU address, valid every cycle
//  cpu_load     in   1   CPU write strobe
//  cpu_wdata    in   DW  CPU write data
//  cpu_rdata    out  DW  read data to the CPU (= mem_rdata)
//  cpu_busy     out  1   stall to the CPU; CPU holds address, load and wdata while high
//  cpu_halt     in   1   host request to freeze the CPU
//  host_req     in   1   host access request; held with addr/we/wdata until host_ack
//  host_we      in   1   1 = write, 0 = read
//  host_addr    in   AW  host address
//  host_wdata   in   DW  host write data
//  host_ack     out  1   registered 1-cycle completion pulse
//  host_rdata   out  DW  captured read data; valid from the host_ack cycle until the next completion
//  mem_address  out  AW  to memory
//  mem_load     out  1   to memory
//  mem_wdata    out  DW  to memory
//  mem_rdata    in   DW  from memory; valid in the same cycle when mem_busy=0
//  mem_busy     in   1   memory stall; the current access completes in the first cycle it is low
// BEHAVIOUR
//  Reset (async assert, sync release): state=CPU, slot_cnt=0, host_ack=0, host_rdata=0.
//  State CPU:
//   - mem_* = cpu_*. With cpu_halt=0: cpu_busy = mem_busy.
//   - With cpu_halt=1: cpu_busy=1 and mem_load=0, so no CPU write reaches memory.
//   - A CPU access completes on a cycle with cpu_halt=0 and mem_busy=0.
//     slot_cnt increments on each completion and saturates at CPU_SLOTS.
//   - Go to HOST when host_req=1, mem_busy=0, and (slot_cnt==CPU_SLOTS or cpu_halt=1).
//     The CPU access in the switching cycle still completes normally.
//  State HOST:
//   - mem_address=host_addr, mem_wdata=host_wdata, mem_load=host_we.
//   - cpu_busy=1 unconditionally.
//   - Stay while mem_busy=1.
//   - When mem_busy=0: on a read, host_rdata <= mem_rdata; on a write, host_rdata is unchanged.
//     In the same edge set host_ack <= 1, slot_cnt <= 0, state <= CPU.
//  host_ack is high for exactly 1 cycle, the first cycle back in CPU. The host drops or
//   changes host_req in that cycle. A host_req still high afterwards is a new request.
//  Host wait after host_req rises:
//   - cpu_halt=1: at most 1 + (memory busy cycles) before entering HOST.
//   - otherwise: bounded by CPU_SLOTS CPU completions.
//  Simultaneous CPU and host readiness with slot_cnt<CPU_SLOTS and cpu_halt=0: CPU wins.
//  mem_load is never asserted in HOST when host_we=0.
//  Reset mid-HOST: the access is abandoned, no ack is issued, the host re-requests.
//  cpu_halt changing mid-HOST has no effect until the return to CPU.
// TESTING
//  1. CPU only: host_req=0, mem_busy=0, 10 CPU writes to 0x0010..0x0019
//     -> all pass through with cpu_busy=0; slot_cnt saturates at 4.
//  2. Host read 0x1234 holding 0xBEEF, slot_cnt=4, mem_busy=0
//     -> HOST next cycle, cpu_busy=1 for 1 cycle, host_ack pulse, host_rdata=0xBEEF.
//  3. host_req asserted just after a host ack (slot_cnt=0)
//     -> exactly 4 CPU completions before the next grant; CPU address stable while cpu_busy=1.
//  4. Host write 0x0042<=0x00FF with mem_busy held high 3 cycles in HOST
//     -> mem_load=1 held 4 cycles, ack in the cycle after busy falls, host_rdata unchanged.
//  5. cpu_halt=1 with a CPU write pending -> mem_load=0, cpu_busy=1;
//     a host read is granted without waiting for CPU slots.
//  6. reset_n pulsed low in HOST with mem_busy=1
//     -> state=CPU, host_ack=0, host_rdata=0 immediately; no ack afterwards.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one data-memory port between the CPU and a host/debug requester.
// CPU traffic passes through; host accesses are slotted in by stalling the CPU.
//
// state | meaning
// ------+-------------------------------------------------------------
// CPU   | memory driven by the CPU; counting completed CPU accesses
// HOST  | memory driven by the host; CPU stalled until the access ends
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int CPU_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic                  cpu_load,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_busy,
  input  logic                  cpu_halt,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_load,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_busy
);

  localparam int CNT_W = $clog2(CPU_SLOTS + 1);
  localparam logic [CNT_W-1:0] SLOT_MAX = CNT_W'(CPU_SLOTS);

  typedef enum logic {
    ST_CPU  = 1'b0,
    ST_HOST = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] slot_cnt;
  logic             cpu_done;
  logic             slots_met;
  logic             host_grant;
  logic             host_done;

  assign cpu_done   = (state == ST_CPU) && !cpu_halt && !mem_busy;
  assign slots_met  = (slot_cnt == SLOT_MAX);
  // A halted CPU gives up its guaranteed slots so the host gets in at once.
  assign host_grant = (state == ST_CPU) && host_req && !mem_busy && (slots_met || cpu_halt);
  assign host_done  = (state == ST_HOST) && !mem_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_CPU;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CPU:  if (host_grant) state_nxt = ST_HOST;
      ST_HOST: if (host_done)  state_nxt = ST_CPU;
      default: state_nxt = ST_CPU;
    endcase
  end

  always_comb begin
    mem_address = cpu_address;
    mem_wdata   = cpu_wdata;
    mem_load    = cpu_load && !cpu_halt;
    cpu_busy    = cpu_halt || mem_busy;
    if (state == ST_HOST) begin
      mem_address = host_addr;
      mem_wdata   = host_wdata;
      mem_load    = host_we;
      cpu_busy    = 1'b1;
    end
  end

  assign cpu_rdata = mem_rdata;

  // The switching cycle still counts as a CPU completion; the count is
  // cleared anyway when the host access finishes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt   <= '0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_ack <= host_done;
      if (host_done) begin
        slot_cnt <= '0;
        if (!host_we) host_rdata <= mem_rdata;
      end else if (cpu_done && !slots_met) begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: CPU pass-through, host read/write slots,
// slot guarantee, CPU halt and reset in the middle of a host access.
module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [15:0] cpu_address;
  logic        cpu_load;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_busy;
  logic        cpu_halt;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic [15:0] mem_address;
  logic        mem_load;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_busy;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .CPU_SLOTS(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_load(cpu_load), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy), .cpu_halt(cpu_halt),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_address(mem_address), .mem_load(mem_load), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy)
  );

  // Memory model: 0x1234 holds 0xBEEF, everything else reads addr ^ 0xA5A5.
  assign mem_rdata = (mem_address == 16'h1234) ? 16'hBEEF : (mem_address ^ 16'hA5A5);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic t3_busy [1:6];
  logic d_busy  [0:5];

  initial begin
    reset_n = 1'b0; cpu_address = '0; cpu_load = 1'b0; cpu_wdata = '0;
    cpu_halt = 1'b0; host_req = 1'b0; host_we = 1'b0; host_addr = '0;
    host_wdata = '0; mem_busy = 1'b0;
    t3_busy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    d_busy  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    #3;
    chk("rst_ack", 32'(host_ack), 0);
    chk("rst_rdata", 32'(host_rdata), 0);
    chk("rst_busy", 32'(cpu_busy), 0);
    tick(); tick();
    reset_n = 1'b1;

    // CPU-only writes, 10 completions
    cpu_load = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cpu_address = 16'(32'h10 + i);
      cpu_wdata   = 16'(32'h100 + i);
      #1;
      chk("t1_addr", 32'(mem_address), 32'h10 + i);
      chk("t1_load", 32'(mem_load), 1);
      chk("t1_wdata", 32'(mem_wdata), 32'h100 + i);
      chk("t1_busy", 32'(cpu_busy), 0);
      tick();
    end

    // Host read with slots already saturated
    cpu_load = 1'b0; cpu_address = 16'h0020;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h1234;
    #1;
    chk("t2_sw_busy", 32'(cpu_busy), 0);
    chk("t2_sw_addr", 32'(mem_address), 32'h0020);
    tick();
    chk("t2_h_busy", 32'(cpu_busy), 1);
    chk("t2_h_addr", 32'(mem_address), 32'h1234);
    chk("t2_h_load", 32'(mem_load), 0);
    chk("t2_h_ack", 32'(host_ack), 0);
    tick();
    host_addr = 16'h0055;
    #1;
    chk("t2_ack", 32'(host_ack), 1);
    chk("t2_rdata", 32'(host_rdata), 32'hBEEF);
    chk("t2_busy", 32'(cpu_busy), 0);

    // New request held from the ack cycle: waits for 4 CPU completions
    for (int k = 1; k <= 6; k++) begin
      tick();
      mem_busy = (k == 1);
      #1;
      chk("t3_busy", 32'(cpu_busy), 32'(t3_busy[k]));
      if (k == 1) begin
        chk("t3_stall_addr", 32'(mem_address), 32'h0020);
        chk("t3_ack_low", 32'(host_ack), 0);
      end
    end
    chk("t3_h_addr", 32'(mem_address), 32'h0055);
    tick();
    host_req = 1'b0;
    #1;
    chk("t3_ack", 32'(host_ack), 1);
    chk("t3_rdata", 32'(host_rdata), 32'hA5F0);
    chk("t3_busy_ack", 32'(cpu_busy), 0);

    // Host write with memory busy for 3 HOST cycles
    tick();
    chk("t4_ack_low", 32'(host_ack), 0);
    tick(); tick(); tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0042; host_wdata = 16'h00FF;
    #1;
    chk("t4_sw_busy", 32'(cpu_busy), 0);
    for (int j = 0; j < 4; j++) begin
      tick();
      mem_busy = (j < 3);
      #1;
      chk("t4_load", 32'(mem_load), 1);
      chk("t4_addr", 32'(mem_address), 32'h0042);
      chk("t4_wdata", 32'(mem_wdata), 32'h00FF);
      chk("t4_ack_low", 32'(host_ack), 0);
      chk("t4_busy", 32'(cpu_busy), 1);
    end
    tick();
    mem_busy = 1'b0; host_req = 1'b0; host_we = 1'b0;
    #1;
    chk("t4_ack", 32'(host_ack), 1);
    chk("t4_rdata_keep", 32'(host_rdata), 32'hA5F0);

    // CPU halt blocks a pending write; host read granted without slots
    tick();
    cpu_halt = 1'b1; cpu_load = 1'b1; cpu_address = 16'h0077; cpu_wdata = 16'h1111;
    #1;
    chk("t5_load", 32'(mem_load), 0);
    chk("t5_busy", 32'(cpu_busy), 1);
    chk("t5_addr", 32'(mem_address), 32'h0077);
    tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h1234;
    #1;
    chk("t5_req_load", 32'(mem_load), 0);
    chk("t5_req_busy", 32'(cpu_busy), 1);
    tick();
    cpu_halt = 1'b0;
    #1;
    chk("t5_h_busy", 32'(cpu_busy), 1);
    chk("t5_h_addr", 32'(mem_address), 32'h1234);
    chk("t5_h_load", 32'(mem_load), 0);
    chk("t5_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
    tick();
    host_req = 1'b0;
    #1;
    chk("t5_ack", 32'(host_ack), 1);
    chk("t5_rdata", 32'(host_rdata), 32'hBEEF);
    chk("t5_busy_rel", 32'(cpu_busy), 0);
    chk("t5_load_rel", 32'(mem_load), 1);
    chk("t5_addr_rel", 32'(mem_address), 32'h0077);

    // Reset in the middle of a stalled host write
    tick();
    cpu_halt = 1'b1; host_req = 1'b1; host_we = 1'b1;
    host_addr = 16'h0099; host_wdata = 16'h5A5A;
    #1;
    chk("t6_busy", 32'(cpu_busy), 1);
    tick();
    mem_busy = 1'b1;
    #1;
    chk("t6_h_addr", 32'(mem_address), 32'h0099);
    chk("t6_h_load", 32'(mem_load), 1);
    cpu_halt = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_ack", 32'(host_ack), 0);
    chk("t6_rst_rdata", 32'(host_rdata), 0);
    chk("t6_rst_addr", 32'(mem_address), 32'h0077);
    chk("t6_rst_load", 32'(mem_load), 1);
    tick(); tick();
    reset_n = 1'b1;
    host_we = 1'b0; host_addr = 16'h1234; mem_busy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      #1;
      chk("t6_busy_seq", 32'(cpu_busy), 32'(d_busy[k]));
      chk("t6_no_ack", 32'(host_ack), 0);
    end
    tick();
    host_req = 1'b0;
    #1;
    chk("t6_ack", 32'(host_ack), 1);
    chk("t6_rdata", 32'(host_rdata), 32'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
